// File: rtl/sdram_target.sv
// sdram_target: behavioural-but-synthesizable 16-bit SDR SDRAM responder.
// Decodes the controller's command bus, tracks one open row per bank,
// honours the mode register (burst length 1/2/4/8, CAS latency 2/3),
// applies DQM, stores data in an internal block RAM and flags the first
// protocol violation made by the controller.
//
// Ports:
//   clk_dram_out          device clock, everything on the rising edge
//   irst                  asynchronous active-high reset
//   m_cke, m_cs_n         clock enable / chip select (command valid when 1/0)
//   m_ras_n/cas_n/we_n    command strobes
//   m_ba, m_a             bank and address bus
//   m_ldqm, m_udqm        byte masks (write: same edge, read: 2 edges early)
//   dq_in                 data bus as seen at the pad
//   dq_out, dq_oe         read data and per-byte output enable ([0] = low)
//   err, err_code         sticky violation flag and code of the first one
//   ref_count             wrapping count of REFRESH commands
//
// Burst engine states:
//   state  | meaning
//   S_IDLE | no burst beats left to issue
//   S_RD   | read burst, issuing beat b_beat into the CAS pipeline
//   S_WR   | write burst, sampling beat b_beat from dq_in
module sdram_target #(
    parameter int COL_W = 4,
    parameter int ROW_W = 6
) (
    input  logic        clk_dram_out,
    input  logic        irst,
    input  logic        m_cke,
    input  logic        m_cs_n,
    input  logic        m_ras_n,
    input  logic        m_cas_n,
    input  logic        m_we_n,
    input  logic [1:0]  m_ba,
    input  logic [12:0] m_a,
    input  logic        m_ldqm,
    input  logic        m_udqm,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic [1:0]  dq_oe,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] ref_count
);
    localparam int AW    = 2 + ROW_W + COL_W;
    localparam int DEPTH = 1 << AW;

    typedef enum logic [2:0] {
        C_MRS = 3'b000, C_REF = 3'b001, C_PRE = 3'b010, C_ACT = 3'b011,
        C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110, C_NOP = 3'b111
    } cmd_t;

    typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} burst_t;

    burst_t           state, state_nxt;
    cmd_t             cmd;
    logic [15:0]      mem [DEPTH];
    logic [3:0]       bank_open;
    logic [ROW_W-1:0] open_row [4];
    logic [1:0]       bl_code;
    logic             cl3;
    logic [1:0]       b_ba;
    logic [ROW_W-1:0] b_row;
    logic [COL_W-1:0] b_col;
    logic [2:0]       b_beat, len_m1;
    logic             cmd_v, rw_ok, rd_go, wr_go, stop;
    logic             acc_rd, acc_wr;
    logic [AW-1:0]    acc_addr, s1_a, s0_a;
    logic             s1_v, s0_v, rd_v;
    logic [15:0]      rd_q;
    logic [1:0]       dqm_d1, dqm_d2;
    logic             err_hit;
    logic [2:0]       err_val;
    logic             unused_a;

    // Sequential burst: column advances within the BL-aligned block and wraps.
    function automatic logic [COL_W-1:0] beat_col(input logic [COL_W-1:0] start,
                                                  input logic [2:0] beat,
                                                  input logic [1:0] blc);
        logic [COL_W-1:0] msk, s;
        msk = COL_W'((8'd1 << blc) - 8'd1);
        s   = start + COL_W'(beat);
        return (start & ~msk) | (s & msk);
    endfunction

    assign unused_a = ^m_a;
    assign cmd_v    = m_cke && !m_cs_n;
    assign cmd      = cmd_t'({m_ras_n, m_cas_n, m_we_n});
    assign rw_ok    = bank_open[m_ba];
    assign rd_go    = cmd_v && cmd == C_RD && rw_ok;
    assign wr_go    = cmd_v && cmd == C_WR && rw_ok;
    assign stop     = rd_go || wr_go || (cmd_v && cmd == C_BST) ||
                      (cmd_v && cmd == C_PRE && (m_a[10] || m_ba == b_ba));
    assign len_m1   = 3'((4'd1 << bl_code) - 4'd1);

    always_ff @(posedge clk_dram_out or posedge irst) begin
        if (irst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        acc_rd    = 1'b0;
        acc_wr    = 1'b0;
        acc_addr  = '0;
        if (m_cke) begin
            if (rd_go || wr_go) begin
                if (len_m1 == 3'd0) state_nxt = S_IDLE;
                else                state_nxt = rd_go ? S_RD : S_WR;
                acc_rd   = rd_go;
                acc_wr   = wr_go;
                acc_addr = {m_ba, open_row[m_ba], m_a[COL_W-1:0]};
            end else if (stop) begin
                state_nxt = S_IDLE;
            end else if (state != S_IDLE) begin
                acc_rd   = (state == S_RD);
                acc_wr   = (state == S_WR);
                acc_addr = {b_ba, b_row, beat_col(b_col, b_beat, bl_code)};
                if (b_beat == len_m1) state_nxt = S_IDLE;
            end
        end
    end

    always_comb begin
        err_hit = 1'b0;
        err_val = 3'd0;
        if (cmd_v) begin
            case (cmd)
                C_RD, C_WR: if (!rw_ok) begin err_hit = 1'b1; err_val = 3'd1; end
                C_ACT:      if (rw_ok)  begin err_hit = 1'b1; err_val = 3'd2; end
                C_REF:      if (|bank_open) begin err_hit = 1'b1; err_val = 3'd3; end
                C_MRS: begin
                    if (|bank_open) begin
                        err_hit = 1'b1; err_val = 3'd4;
                    end else if (m_a[2] || !(m_a[6:4] == 3'd2 || m_a[6:4] == 3'd3)) begin
                        err_hit = 1'b1; err_val = 3'd5;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_dram_out or posedge irst) begin
        if (irst) begin
            dq_out    <= '0;
            dq_oe     <= '0;
            err       <= 1'b0;
            err_code  <= '0;
            ref_count <= '0;
            bank_open <= '0;
            for (int i = 0; i < 4; i++) open_row[i] <= '0;
            bl_code   <= 2'd0;
            cl3       <= 1'b0;
            b_ba      <= '0;
            b_row     <= '0;
            b_col     <= '0;
            b_beat    <= '0;
            s1_v      <= 1'b0;
            s1_a      <= '0;
            s0_v      <= 1'b0;
            s0_a      <= '0;
            rd_v      <= 1'b0;
            dqm_d1    <= '0;
            dqm_d2    <= '0;
        end else if (m_cke) begin
            if (rd_go || wr_go) begin
                b_ba   <= m_ba;
                b_row  <= open_row[m_ba];
                b_col  <= m_a[COL_W-1:0];
                b_beat <= 3'd1;
            end else if (state != S_IDLE && !stop) begin
                b_beat <= b_beat + 3'd1;
            end

            if (err_hit && !err) begin
                err      <= 1'b1;
                err_code <= err_val;
            end

            if (cmd_v) begin
                case (cmd)
                    C_ACT: if (!rw_ok) begin
                        bank_open[m_ba] <= 1'b1;
                        open_row[m_ba]  <= m_a[ROW_W-1:0];
                    end
                    C_PRE: if (m_a[10]) bank_open <= '0;
                           else         bank_open[m_ba] <= 1'b0;
                    C_REF: ref_count <= ref_count + 16'd1;
                    C_MRS: if (bank_open == 4'd0) begin
                        // Each field is applied independently when legal.
                        if (!m_a[2]) bl_code <= m_a[1:0];
                        if (m_a[6:4] == 3'd2 || m_a[6:4] == 3'd3) cl3 <= m_a[4];
                    end
                    default: ;
                endcase
            end

            // CAS pipeline: issue -> (s1 when CL3) -> s0 -> RAM read -> pad.
            s1_v   <= acc_rd && cl3;
            s1_a   <= acc_addr;
            s0_v   <= cl3 ? s1_v : acc_rd;
            s0_a   <= cl3 ? s1_a : acc_addr;
            rd_v   <= s0_v;
            dqm_d1 <= {m_udqm, m_ldqm};
            dqm_d2 <= dqm_d1;
            if (rd_v) dq_out <= rd_q;
            dq_oe  <= rd_v ? ~dqm_d2 : 2'b00;

            // A write takes the bus: drop every read beat still in flight.
            if (wr_go) begin
                s1_v  <= 1'b0;
                s0_v  <= 1'b0;
                rd_v  <= 1'b0;
                dq_oe <= 2'b00;
            end
        end
    end

    always_ff @(posedge clk_dram_out) begin
        if (m_cke) begin
            if (acc_wr && !m_ldqm) mem[acc_addr][7:0]  <= dq_in[7:0];
            if (acc_wr && !m_udqm) mem[acc_addr][15:8] <= dq_in[15:8];
            rd_q <= mem[s0_a];
        end
    end
endmodule

// File: tb/tb_sdram_target.sv
module tb_sdram_target;
    logic        clk = 1'b0;
    logic        irst = 1'b1;
    logic        cke = 1'b1, cs_n = 1'b0, ras_n = 1'b1, cas_n = 1'b1, we_n = 1'b1;
    logic [1:0]  ba = '0;
    logic [12:0] a = '0;
    logic        ldqm = 1'b0, udqm = 1'b0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic [1:0]  dq_oe;
    logic        err;
    logic [2:0]  err_code;
    logic [15:0] ref_count;

    sdram_target dut (
        .clk_dram_out(clk), .irst(irst), .m_cke(cke), .m_cs_n(cs_n),
        .m_ras_n(ras_n), .m_cas_n(cas_n), .m_we_n(we_n), .m_ba(ba), .m_a(a),
        .m_ldqm(ldqm), .m_udqm(udqm), .dq_in(dq_in), .dq_out(dq_out),
        .dq_oe(dq_oe), .err(err), .err_code(err_code), .ref_count(ref_count)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          cyc;
        logic [15:0] data;
        logic [15:0] dmask;
        logic [1:0]  oe;
    } exp_t;
    exp_t sbq[$];
    exp_t mon_e;
    bit   mon_en = 1'b0;

    // Reference model: flat memory with per-bit "known" mask, mode, banks.
    logic [15:0] model [4096];
    logic [15:0] known [4096];
    int          m_bl, m_cl, m_ref, m_code;
    bit          m_err;
    int          m_row [4];
    bit          m_open [4];
    logic [15:0] wdat [8];
    logic [1:0]  wm [8];

    function automatic int maddr(int b, int r, int col, int k, int len);
        int base;
        base = col - (col % len);
        return b * 1024 + (r % 64) * 16 + base + ((col + k) % len);
    endfunction

    function automatic bit any_open();
        return m_open[0] || m_open[1] || m_open[2] || m_open[3];
    endfunction

    function automatic void set_err(int code);
        if (!m_err) begin
            m_err  = 1'b1;
            m_code = code;
        end
    endfunction

    function automatic void model_reset();
        m_bl = 1; m_cl = 2; m_ref = 0; m_err = 1'b0; m_code = 0;
        for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
        sbq.delete();
    endfunction

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic chk_err(input string name);
        check({name, "_err"}, int'(err), int'(m_err));
        check({name, "_code"}, int'(err_code), m_code);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic bus_nop();
        cs_n = 1'b0; {ras_n, cas_n, we_n} = 3'b111; ldqm = 1'b0; udqm = 1'b0;
    endtask

    task automatic cmd(input logic [2:0] c, input int b, input int addr);
        {ras_n, cas_n, we_n} = c; ba = 2'(b); a = 13'(addr);
        tick();
        {ras_n, cas_n, we_n} = 3'b111;
    endtask

    task automatic reset_pulse();
        mon_en = 1'b0;
        irst = 1'b1;
        tick();
        irst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        tick();
    endtask

    task automatic mrs(input int bl_f, input int cl_f);
        if (any_open()) set_err(4);
        else begin
            if (bl_f > 3 || !(cl_f == 2 || cl_f == 3)) set_err(5);
            if (bl_f <= 3) m_bl = 1 << bl_f;
            if (cl_f == 2 || cl_f == 3) m_cl = cl_f;
        end
        cmd(3'b000, 0, cl_f * 16 + bl_f);
    endtask

    task automatic act(input int b, input int r);
        if (m_open[b]) set_err(2);
        else begin
            m_open[b] = 1'b1;
            m_row[b]  = r;
        end
        cmd(3'b011, b, r);
    endtask

    task automatic pre_all();
        for (int i = 0; i < 4; i++) m_open[i] = 1'b0;
        cmd(3'b010, 0, 13'h400);
    endtask

    task automatic refresh();
        if (any_open()) set_err(3);
        m_ref = (m_ref + 1) % 65536;
        cmd(3'b001, 0, 0);
    endtask

    task automatic do_write(input int b, input int col, input int nb);
        int len;
        bit ok;
        int ad;
        len = m_bl;
        ok  = m_open[b];
        if (!ok) set_err(1);
        for (int k = 0; k < nb; k++) begin
            dq_in = wdat[k]; ldqm = wm[k][0]; udqm = wm[k][1];
            if (k == 0) begin
                {ras_n, cas_n, we_n} = 3'b100; ba = 2'(b); a = 13'(col);
            end else {ras_n, cas_n, we_n} = 3'b111;
            tick();
            if (ok) begin
                ad = maddr(b, m_row[b], col, k, len);
                if (!wm[k][0]) begin model[ad][7:0]  = wdat[k][7:0];  known[ad][7:0]  = 8'hFF; end
                if (!wm[k][1]) begin model[ad][15:8] = wdat[k][15:8]; known[ad][15:8] = 8'hFF; end
            end
        end
        bus_nop();
        if (nb < len) cmd(3'b110, 0, 0);
    endtask

    task automatic do_read(input int b, input int col, input int moff);
        int   e0;
        int   len;
        int   ad;
        exp_t e;
        e0  = edge_cnt + 1;
        len = m_bl;
        if (m_open[b]) begin
            for (int k = 0; k < len; k++) begin
                ad      = maddr(b, m_row[b], col, k, len);
                e.cyc   = e0 + m_cl + k;
                e.data  = model[ad];
                e.dmask = known[ad];
                e.oe    = (m_cl + k - 2 == moff) ? 2'b01 : 2'b11;
                sbq.push_back(e);
            end
        end else set_err(1);
        for (int i = 0; i <= m_cl + len; i++) begin
            udqm = (i == moff);
            if (i == 0) begin
                {ras_n, cas_n, we_n} = 3'b101; ba = 2'(b); a = 13'(col);
            end else {ras_n, cas_n, we_n} = 3'b111;
            tick();
        end
        bus_nop();
    endtask

    task automatic rand_wdata();
        for (int k = 0; k < 8; k++) begin
            wdat[k] = 16'($urandom);
            wm[k]   = 2'b00;
        end
    endtask

    // Monitor: every read beat the model predicts is matched at its edge;
    // any enable outside a predicted beat is reported.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sbq.size() > 0 && sbq[0].cyc < edge_cnt) begin
                errors++;
                $display("FAIL rd_missing: beat due at edge %0d not seen (now %0d)", sbq[0].cyc, edge_cnt);
                void'(sbq.pop_front());
            end
            if (sbq.size() > 0 && sbq[0].cyc == edge_cnt) begin
                mon_e = sbq.pop_front();
                checks++;
                if (dq_oe !== mon_e.oe || ((dq_out ^ mon_e.data) & mon_e.dmask) !== 16'h0) begin
                    errors++;
                    $display("FAIL rd_beat @%0d: got oe=%b data=%h expected oe=%b data=%h mask=%h",
                             edge_cnt, dq_oe, dq_out, mon_e.oe, mon_e.data, mon_e.dmask);
                end
            end else if (dq_oe !== 2'b00) begin
                errors++;
                $display("FAIL rd_spurious @%0d: got oe=%b expected oe=00", edge_cnt, dq_oe);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, col, nb, moff, e0;
        for (int i = 0; i < 4096; i++) begin model[i] = '0; known[i] = '0; end
        for (int i = 0; i < 4; i++) m_row[i] = 0;
        model_reset();
        bus_nop();
        repeat (3) tick();
        check("rst_dq_out", int'(dq_out), 0);
        check("rst_dq_oe", int'(dq_oe), 0);
        check("rst_err", int'(err), 0);
        check("rst_err_code", int'(err_code), 0);
        check("rst_ref_count", int'(ref_count), 0);
        irst = 1'b0;
        mon_en = 1'b1;
        tick();

        // BL=4 CL=2 wrap inside the 4-word block
        mrs(2, 2);
        act(1, 5);
        wdat[0] = 16'h1111; wdat[1] = 16'h2222; wdat[2] = 16'h3333; wdat[3] = 16'h4444;
        for (int k = 0; k < 8; k++) wm[k] = 2'b00;
        do_write(1, 2, 4);
        do_read(1, 0, -1);
        do_read(1, 2, -1);

        // WRITE three edges after a READ drops the beats still in flight
        e0 = edge_cnt + 1;
        mon_e.cyc = e0 + 2; mon_e.data = model[maddr(1, 5, 1, 0, 4)];
        mon_e.dmask = known[maddr(1, 5, 1, 0, 4)]; mon_e.oe = 2'b11;
        sbq.push_back(mon_e);
        cmd(3'b101, 1, 1);
        tick();
        tick();
        rand_wdata();
        do_write(1, 0, 4);
        check("oe_after_wr", int'(dq_oe), 0);
        do_read(1, 0, -1);

        // CL=3 BL=1 with upper mask one edge after the command
        pre_all();
        mrs(0, 3);
        act(1, 5);
        do_read(1, 2, 1);
        do_read(1, 3, -1);

        // BL=8: masked beat 3, then a BST-shortened burst
        pre_all();
        mrs(3, 2);
        act(2, 9);
        rand_wdata(); do_write(2, 0, 8);
        rand_wdata(); do_write(2, 8, 8);
        rand_wdata(); wm[3] = 2'b01; do_write(2, 0, 8);
        do_read(2, 0, -1);
        rand_wdata(); do_write(2, 8, 5);
        do_read(2, 8, -1);
        do_read(2, 13, 4);

        // Randomised traffic
        pre_all();
        mrs(2, 3);
        for (int i = 0; i < 4; i++) act(i, $urandom_range(0, 63));
        for (int it = 0; it < 40; it++) begin
            int op;
            op  = $urandom_range(0, 9);
            b   = $urandom_range(0, 3);
            col = $urandom_range(0, 15);
            if (op == 0) begin
                pre_all();
                mrs($urandom_range(0, 3), $urandom_range(2, 3));
                for (int i = 0; i < 4; i++) act(i, $urandom_range(0, 63));
            end else if (op < 5) begin
                rand_wdata();
                for (int k = 0; k < 8; k++)
                    if ($urandom_range(0, 3) == 0) wm[k] = 2'($urandom_range(1, 3));
                nb = m_bl;
                if (m_bl > 1 && $urandom_range(0, 3) == 0) nb = $urandom_range(1, m_bl - 1);
                do_write(b, col, nb);
            end else begin
                moff = $urandom_range(0, 8) - 2;
                do_read(b, col, moff);
            end
        end
        chk_err("rand");

        // READ to an idle bank, then ACT on an open bank keeps code 1
        pre_all();
        do_read(0, 0, -1);
        chk_err("rd_idle");
        act(2, 3);
        act(2, 4);
        chk_err("act_after");

        reset_pulse();
        act(0, 1);
        act(0, 2);
        chk_err("act_open");

        reset_pulse();
        act(3, 4);
        refresh();
        chk_err("ref_open");
        check("ref_open_cnt", int'(ref_count), m_ref);

        reset_pulse();
        act(0, 0);
        mrs(1, 2);
        chk_err("mrs_open");

        reset_pulse();
        mrs(5, 3);
        chk_err("mrs_bad_bl");
        act(1, 5);
        do_read(1, 2, -1);

        // CKE low ignores commands; refresh counting; reset mid-burst
        reset_pulse();
        cke = 1'b0;
        cmd(3'b001, 0, 0);
        cke = 1'b1;
        check("cke_ref", int'(ref_count), m_ref);
        refresh(); refresh(); refresh();
        check("ref3_cnt", int'(ref_count), m_ref);
        chk_err("ref3");
        mrs(3, 2);
        act(1, 5);
        mon_en = 1'b0;
        cmd(3'b101, 1, 0);
        tick(); tick(); tick();
        check("burst_live_oe", int'(dq_oe), 3);
        #1 irst = 1'b1;
        #1;
        check("rst_mid_oe", int'(dq_oe), 0);
        check("rst_mid_ref", int'(ref_count), 0);
        check("rst_mid_err", int'(err), 0);
        tick();
        irst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        tick();
        act(1, 5);
        do_read(1, 2, -1);
        do_read(1, 0, 0);
        tick(); tick();

        check("sb_empty", sbq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
